// File: rtl/vram_arbiter_pkg.sv
// Shared frame-buffer geometry and arbiter state encodings, common to the
// VGA timing block and the VRAM arbiter.
package vram_arbiter_pkg;

  localparam int H_ACTIVE    = 640;
  localparam int V_ACTIVE    = 480;
  localparam int SCALE_SHIFT = 3;
  localparam int FB_AW       = 13;
  localparam int FB_W        = H_ACTIVE >> SCALE_SHIFT;
  localparam int FB_DEPTH    = FB_W * (V_ACTIVE >> SCALE_SHIFT);

  localparam int COL_W = 10;
  localparam int ROW_W = 9;
  localparam int RGB_W = 3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_RDW  = 2'd2;
  localparam logic [1:0] S_WR   = 2'd3;

  function automatic logic fb_in_range(input logic [FB_AW-1:0] addr);
    return int'(addr) < FB_DEPTH;
  endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// MiniAlu pixel-write channel: request held with address/data until a
// one-cycle ack (optionally flagged as an out-of-range error).
interface vram_arbiter_if;
  import vram_arbiter_pkg::*;

  logic             wr_req;
  logic [FB_AW-1:0] wr_addr;
  logic [RGB_W-1:0] wr_data;
  logic             wr_ack;
  logic             wr_err;

  modport master (output wr_req, wr_addr, wr_data, input wr_ack, wr_err);
  modport slave  (input wr_req, wr_addr, wr_data, output wr_ack, wr_err);

endinterface

// File: rtl/vram_addr_gen.sv
// Maps the current scan position to a frame-buffer cell address and
// reports whether the position lies inside the visible area.
module vram_addr_gen
  import vram_arbiter_pkg::*;
(
  input  logic [COL_W-1:0] column_count,
  input  logic [ROW_W-1:0] row_count,
  output logic [FB_AW-1:0] rd_addr,
  output logic             vis
);

  localparam logic [FB_AW-1:0] FB_W_A = FB_AW'(FB_W);

  logic [FB_AW-1:0] cell_col;
  logic [FB_AW-1:0] cell_row;

  assign cell_col = FB_AW'(column_count >> SCALE_SHIFT);
  assign cell_row = FB_AW'(row_count >> SCALE_SHIFT);
  assign rd_addr  = cell_row * FB_W_A + cell_col;
  assign vis      = (column_count < COL_W'(H_ACTIVE)) && (row_count < ROW_W'(V_ACTIVE));

endmodule

// File: rtl/vram_arbiter.sv
// Single-port frame-buffer arbiter: scanout reads take priority, MiniAlu
// writes fill the idle RAM cycles, and the fetched pixel drives the VGA pins.
module vram_arbiter
  import vram_arbiter_pkg::*;
(
  input  logic             Clock,
  input  logic             Reset,
  input  logic [COL_W-1:0] column_count,
  input  logic [ROW_W-1:0] row_count,
  vram_arbiter_if.slave    wr_bus,
  output logic [FB_AW-1:0] ram_addr,
  output logic             ram_we,
  output logic [RGB_W-1:0] ram_din,
  input  logic [RGB_W-1:0] ram_dout,
  output logic [RGB_W-1:0] pixel_rgb,
  output logic             frame_start
);

  logic [COL_W-1:0] col_q_reg;
  logic [ROW_W-1:0] row_q_reg;
  logic             evt;
  logic             vis;
  logic             rd_hit;
  logic [FB_AW-1:0] rd_addr;

  logic [1:0]       state_reg;
  logic [1:0]       state_next;
  logic             rd_pending_reg;
  logic [FB_AW-1:0] rd_addr_reg;
  logic [RGB_W-1:0] pix_reg;
  logic [2:0]       vis_pipe_reg;
  logic             frame_start_reg;
  logic             wr_in_range;

  vram_addr_gen u_addr_gen (
    .column_count (column_count),
    .row_count    (row_count),
    .rd_addr      (rd_addr),
    .vis          (vis)
  );

  assign evt         = (column_count != col_q_reg) || (row_count != row_q_reg);
  assign rd_hit      = evt && vis;
  assign wr_in_range = fb_in_range(wr_bus.wr_addr);

  always_comb begin
    state_next = S_IDLE;
    case (state_reg)
      S_IDLE: begin
        if (rd_hit || rd_pending_reg) state_next = S_RD;
        else if (wr_bus.wr_req)       state_next = S_WR;
        else                          state_next = S_IDLE;
      end
      S_RD:    state_next = S_RDW;
      S_RDW:   state_next = S_IDLE;
      S_WR:    state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      col_q_reg       <= '0;
      row_q_reg       <= '0;
      state_reg       <= S_IDLE;
      rd_pending_reg  <= 1'b0;
      rd_addr_reg     <= '0;
      pix_reg         <= '0;
      vis_pipe_reg    <= '0;
      frame_start_reg <= 1'b0;
    end else begin
      col_q_reg       <= column_count;
      row_q_reg       <= row_count;
      state_reg       <= state_next;
      vis_pipe_reg    <= {vis_pipe_reg[1:0], vis};
      frame_start_reg <= evt && (column_count == '0) && (row_count == '0);
      if (state_reg == S_RDW) pix_reg <= ram_dout;
      // The newest visible position always wins; an older unserved one is stale.
      if (rd_hit) rd_addr_reg <= rd_addr;
      if (state_reg == S_IDLE) rd_pending_reg <= 1'b0;
      else if (rd_hit)         rd_pending_reg <= 1'b1;
    end
  end

  // RAM port and write handshake decode straight from the state; a request
  // withdrawn during S_WR is neither written nor acked.
  always_comb begin
    ram_addr       = '0;
    ram_we         = 1'b0;
    ram_din        = '0;
    wr_bus.wr_ack  = 1'b0;
    wr_bus.wr_err  = 1'b0;
    if (!Reset) begin
      case (state_reg)
        S_RD: ram_addr = rd_addr_reg;
        S_WR: begin
          if (wr_bus.wr_req) begin
            wr_bus.wr_ack = 1'b1;
            if (wr_in_range) begin
              ram_we   = 1'b1;
              ram_addr = wr_bus.wr_addr;
              ram_din  = wr_bus.wr_data;
            end else begin
              wr_bus.wr_err = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign pixel_rgb   = vis_pipe_reg[2] ? pix_reg : '0;
  assign frame_start = frame_start_reg;

endmodule
